alu_reg_unit: RTL and testbench



---
 rtl/alu_reg_pkg.sv | 15 +
 rtl/alu_core.sv | 32 +++
 rtl/alu_reg_unit.sv | 54 +++++
 tb/tb_alu_reg_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_reg_pkg.sv
// Shared constants for alu_reg_unit: default datapath width and ALU opcode encodings.
package alu_reg_pkg;

    localparam int ALU_DATA_W = 4;

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU, results modulo 2^DATA_W.
// Multiply/divide exist only when ALU_MULDIV_EN is defined; otherwise those opcodes give 0.
module alu_core
    import alu_reg_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [2:0]        oc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] f
);

    always_comb begin
        f = '0;
        case (oc)
            OC_ADD: f = a + b;
            OC_SUB: f = a - b;
`ifdef ALU_MULDIV_EN
            OC_MUL: f = a * b;
            // Divide by zero is defined as 0 rather than all-ones.
            OC_DIV: f = (b == '0) ? '0 : a / b;
`endif
            OC_NOT: f = ~a;
            OC_XOR: f = a ^ b;
            OC_OR:  f = a | b;
            OC_AND: f = a & b;
            default: f = '0;
        endcase
    end

endmodule

// File: rtl/alu_reg_unit.sv
// ALU plus independent multi-function register (cl > ld > inc > dec > sr > sl > hold).
// Optional macro ALU_MULDIV_EN enables the ALU multiply and divide opcodes.
module alu_reg_unit
    import alu_reg_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        oc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] f,
    input  logic              cl,
    input  logic              ld,
    input  logic              inc,
    input  logic              dec,
    input  logic              sr,
    input  logic              ir,
    input  logic              sl,
    input  logic              il,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out
);

    alu_core #(
        .DATA_W (DATA_W)
    ) u_alu_core (
        .oc (oc),
        .a  (a),
        .b  (b),
        .f  (f)
    );

    // Only the highest-priority asserted control acts; ir/il matter only for their own shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (cl) begin
            out <= '0;
        end else if (ld) begin
            out <= in;
        end else if (inc) begin
            out <= out + DATA_W'(1);
        end else if (dec) begin
            out <= out - DATA_W'(1);
        end else if (sr) begin
            out <= {ir, out[DATA_W-1:1]};
        end else if (sl) begin
            out <= {out[DATA_W-2:0], il};
        end
    end

endmodule

// File: tb/tb_alu_reg_unit.sv
// Self-checking bench for alu_reg_unit: exhaustive ALU sweep, directed register cases, random register run.
module tb_alu_reg_unit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [2:0]   oc;
    logic [W-1:0] a, b, f;
    logic         cl, ld, inc, dec, sr, ir, sl, il;
    logic [W-1:0] in, out;

    int checks   = 0;
    int failures = 0;
    int model;

    always #5 clk = ~clk;

    alu_reg_unit #(.DATA_W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .oc    (oc),
        .a     (a),
        .b     (b),
        .f     (f),
        .cl    (cl),
        .ld    (ld),
        .inc   (inc),
        .dec   (dec),
        .sr    (sr),
        .ir    (ir),
        .sl    (sl),
        .il    (il),
        .in    (in),
        .out   (out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic int alu_ref(input int op, input int x, input int y);
        int r;
        case (op)
            0: r = x + y;
            1: r = x - y;
`ifdef ALU_MULDIV_EN
            2: r = x * y;
            3: r = (y == 0) ? 0 : x / y;
`else
            2: r = 0;
            3: r = 0;
`endif
            4: r = 15 - x;
            5: r = x ^ y;
            6: r = x | y;
            default: r = x & y;
        endcase
        return r & ((1 << W) - 1);
    endfunction

    function automatic int reg_ref(input int q, input int c, input int l, input int i,
                                   input int d, input int r, input int rb, input int s,
                                   input int lb, input int din);
        if (c != 0) return 0;
        if (l != 0) return din;
        if (i != 0) return (q + 1) % 16;
        if (d != 0) return (q + 15) % 16;
        if (r != 0) return q / 2 + rb * 8;
        if (s != 0) return (q * 2) % 16 + lb;
        return q;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic l, input logic i, input logic d,
                         input logic r, input logic rb, input logic s, input logic lb,
                         input logic [W-1:0] din);
        cl = c; ld = l; inc = i; dec = d; sr = r; ir = rb; sl = s; il = lb; in = din;
    endtask

    task automatic load_value(input logic [W-1:0] v);
        drive(0, 1, 0, 0, 0, 0, 0, 0, v);
        tick;
    endtask

    task automatic alu_spot(input string tag, input int op, input int x, input int y, input int want);
        oc = 3'(op); a = W'(x); b = W'(y);
        #1;
        check(tag, 32'(f), 32'(want));
    endtask

    initial begin
        rst_n = 1'b0;
        oc = '0; a = '0; b = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, '0);
        #2;
        check("reset_out", 32'(out), 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        check("hold_after_reset", 32'(out), 0);

        for (int o = 0; o < 8; o++)
            for (int x = 0; x < 16; x++)
                for (int y = 0; y < 16; y++) begin
                    oc = 3'(o); a = W'(x); b = W'(y);
                    #1;
                    check("alu_sweep", 32'(f), 32'(alu_ref(o, x, y)));
                end

        alu_spot("spot_add_wrap", 0, 15, 1, 0);
        alu_spot("spot_sub_wrap", 1, 0, 1, 15);
`ifdef ALU_MULDIV_EN
        alu_spot("spot_mul", 2, 5, 3, 15);
        alu_spot("spot_div", 3, 7, 2, 3);
`else
        alu_spot("spot_mul_off", 2, 5, 3, 0);
        alu_spot("spot_div_off", 3, 7, 2, 0);
`endif
        alu_spot("spot_div_zero", 3, 9, 0, 0);
        alu_spot("spot_not", 4, 10, 0, 5);

        tick;
        load_value(4'b0101);
        check("load", 32'(out), 5);

        // Asynchronous reset asserted mid-cycle while a load is pending.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 4'b1010);
        #3 rst_n = 1'b0;
        #1 check("async_reset", 32'(out), 0);
        tick;
        check("reset_hold_edge", 32'(out), 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        check("reset_release", 32'(out), 10);

        drive(1, 1, 1, 1, 1, 1, 1, 1, 4'b1111);
        #2 rst_n = 1'b0;
        #1 check("async_reset_all_high", 32'(out), 0);
        @(negedge clk) rst_n = 1'b1;
        tick;
        check("clear_after_release", 32'(out), 0);

        load_value(4'b1111);
        drive(0, 0, 1, 0, 0, 0, 0, 0, '0);
        tick;
        check("inc_wrap", 32'(out), 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0, '0);
        tick;
        check("dec_wrap", 32'(out), 15);

        load_value(4'b1001);
        drive(0, 0, 0, 0, 1, 1, 0, 0, '0);
        tick;
        check("shift_right", 32'(out), 12);
        load_value(4'b1001);
        drive(0, 0, 0, 0, 0, 0, 1, 0, '0);
        tick;
        check("shift_left", 32'(out), 2);

        load_value(4'b0101);
        drive(1, 1, 1, 1, 1, 1, 1, 1, 4'b0011);
        tick;
        check("prio_cl", 32'(out), 0);
        load_value(4'b0101);
        drive(0, 1, 1, 1, 1, 1, 1, 1, 4'b0011);
        tick;
        check("prio_ld", 32'(out), 3);
        load_value(4'b0101);
        drive(0, 0, 1, 1, 1, 1, 1, 1, 4'b0011);
        tick;
        check("prio_inc", 32'(out), 6);

        model = 6;
        for (int n = 0; n < 1000; n++) begin
            int c, l, i, d, r, rb, s, lb, din, op, x, y;
            c  = ($urandom_range(0, 7) == 0) ? 1 : 0;
            l  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            i  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            d  = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            s  = ($urandom_range(0, 2) == 0) ? 1 : 0;
            rb = $urandom_range(0, 1);
            lb = $urandom_range(0, 1);
            din = $urandom_range(0, 15);
            op = $urandom_range(0, 7);
            x  = $urandom_range(0, 15);
            y  = $urandom_range(0, 15);
            drive(c[0], l[0], i[0], d[0], r[0], rb[0], s[0], lb[0], W'(din));
            oc = 3'(op); a = W'(x); b = W'(y);
            #1;
            check("rand_alu", 32'(f), 32'(alu_ref(op, x, y)));
            tick;
            model = reg_ref(model, c, l, i, d, r, rb, s, lb, din);
            check("rand_reg", 32'(out), 32'(model));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
